// File: rtl/disp_share_arb.sv
// Two-client round-robin arbiter for the shared 4-digit seven-segment display,
// holding each grant for a minimum dwell. Optional owner-dp blink: DISP_ARB_WAIT_BLINK_EN.
module disp_share_arb #(
  parameter int TICK_DIV = 5000000,
  parameter int DWELL    = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] val0,
  input  logic [3:0]  dp0,
  input  logic        req1,
  input  logic [15:0] val1,
  input  logic [3:0]  dp1,
  output logic [1:0]  grant,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic [DW-1:0]   dwell;
  logic            dwell_full;
  logic            rr_fav;
  logic            state_change;
  logic            blink_d;
  logic [1:0]      grant_d;
  logic [15:0]     hex_d;
  logic [3:0]      dp_d;

  // Free-running prescaler; grant changes never disturb its phase.
  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign dwell_full   = (dwell == DW'(DWELL));
  assign state_change = (next_state != state);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          next_state = rr_fav ? GNT1 : GNT0;
        end else if (req0) begin
          next_state = GNT0;
        end else if (req1) begin
          next_state = GNT1;
        end
      end
      GNT0: begin
        if (!req0) begin
          next_state = req1 ? GNT1 : IDLE;
        end else if (dwell_full && req1) begin
          next_state = GNT1;
        end
      end
      GNT1: begin
        if (!req1) begin
          next_state = req0 ? GNT0 : IDLE;
        end else if (dwell_full && req0) begin
          next_state = GNT0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A tick landing on a transition is dropped because the clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell <= '0;
    end else if (state_change) begin
      dwell <= '0;
    end else if ((state != IDLE) && tick && !dwell_full) begin
      dwell <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_fav <= 1'b0;
    end else if (state_change && (next_state == GNT0)) begin
      rr_fav <= 1'b1;
    end else if (state_change && (next_state == GNT1)) begin
      rr_fav <= 1'b0;
    end
  end

`ifdef DISP_ARB_WAIT_BLINK_EN
  logic blink;
  logic other_waiting;

  assign other_waiting = ((state == GNT0) && req1) || ((state == GNT1) && req0);

  always_comb begin
    blink_d = blink;
    if (state_change || !other_waiting) begin
      blink_d = 1'b0;
    end else if (tick) begin
      blink_d = ~blink;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink <= 1'b0;
    end else begin
      blink <= blink_d;
    end
  end
`else
  assign blink_d = 1'b0;
`endif

  // Output mux keyed by next state so the first grant cycle already shows the new owner.
  always_comb begin
    grant_d = 2'b00;
    hex_d   = 16'h0000;
    dp_d    = 4'b1111;
    case (next_state)
      GNT0: begin
        grant_d = 2'b01;
        hex_d   = val0;
        dp_d    = dp0 ^ {4{blink_d}};
      end
      GNT1: begin
        grant_d = 2'b10;
        hex_d   = val1;
        dp_d    = dp1 ^ {4{blink_d}};
      end
      default: begin
        grant_d = 2'b00;
        hex_d   = 16'h0000;
        dp_d    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant  <= 2'b00;
      hex3   <= 4'h0;
      hex2   <= 4'h0;
      hex1   <= 4'h0;
      hex0   <= 4'h0;
      dp_out <= 4'b1111;
    end else begin
      grant  <= grant_d;
      hex3   <= hex_d[15:12];
      hex2   <= hex_d[11:8];
      hex1   <= hex_d[7:4];
      hex0   <= hex_d[3:0];
      dp_out <= dp_d;
    end
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// Bench for disp_share_arb: ownership model checked every cycle plus hand-computed checkpoints.
module tb_disp_share_arb;

  localparam int TICK_DIV = 4;
  localparam int DWELL    = 3;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [15:0] val0;
  logic [3:0]  dp0;
  logic        req1;
  logic [15:0] val1;
  logic [3:0]  dp1;
  logic [1:0]  grant;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;
  logic [3:0]  dp_out;

  int checks   = 0;
  int failures = 0;

  disp_share_arb #(
    .TICK_DIV(TICK_DIV),
    .DWELL   (DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .val0  (val0),
    .dp0   (dp0),
    .req1  (req1),
    .val1  (val1),
    .dp1   (dp1),
    .grant (grant),
    .hex3  (hex3),
    .hex2  (hex2),
    .hex1  (hex1),
    .hex0  (hex0),
    .dp_out(dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the display, how many ticks it has held it, who wins the next tie.
  int        m_owner = -1;
  int        m_held  = 0;
  int        m_fav   = 0;
  int        m_cyc   = 0;
  bit        m_blink = 1'b0;
  bit        m_valid = 1'b0;
  int        m_new;
  bit        m_tick;
  bit        m_req [2];
  logic [1:0]  exp_grant;
  logic [15:0] exp_hex;
  logic [3:0]  exp_dp;

  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      m_owner = -1;
      m_held  = 0;
      m_fav   = 0;
      m_cyc   = 0;
      m_blink = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_cyc    = m_cyc + 1;
      m_tick   = ((m_cyc % TICK_DIV) == 0);
      m_req[0] = req0;
      m_req[1] = req1;
      if (m_owner < 0) begin
        if (m_req[0] && m_req[1]) m_new = m_fav;
        else if (m_req[0])        m_new = 0;
        else if (m_req[1])        m_new = 1;
        else                      m_new = -1;
      end else if (!m_req[m_owner]) begin
        m_new = m_req[1 - m_owner] ? 1 - m_owner : -1;
      end else if (m_held == DWELL && m_req[1 - m_owner]) begin
        m_new = 1 - m_owner;
      end else begin
        m_new = m_owner;
      end
      if (m_new != m_owner) begin
        m_held  = 0;
        m_blink = 1'b0;
        if (m_new >= 0) m_fav = 1 - m_new;
      end else if (m_owner >= 0) begin
        if (m_tick && m_held < DWELL) m_held = m_held + 1;
`ifdef DISP_ARB_WAIT_BLINK_EN
        if (!m_req[1 - m_owner]) m_blink = 1'b0;
        else if (m_tick)         m_blink = ~m_blink;
`endif
      end
      m_owner = m_new;
    end
    if (m_valid) begin
      if (m_owner == 0) begin
        exp_grant = 2'b01;
        exp_hex   = val0;
        exp_dp    = dp0 ^ {4{m_blink}};
      end else if (m_owner == 1) begin
        exp_grant = 2'b10;
        exp_hex   = val1;
        exp_dp    = dp1 ^ {4{m_blink}};
      end else begin
        exp_grant = 2'b00;
        exp_hex   = 16'h0000;
        exp_dp    = 4'b1111;
      end
      checks = checks + 3;
      if (grant !== exp_grant) begin
        failures = failures + 1;
        $display("[TB] FAIL model_grant t=%0t got=%b want=%b", $time, grant, exp_grant);
      end
      if ({hex3, hex2, hex1, hex0} !== exp_hex) begin
        failures = failures + 1;
        $display("[TB] FAIL model_hex t=%0t got=%h want=%h", $time, {hex3, hex2, hex1, hex0}, exp_hex);
      end
      if (dp_out !== exp_dp) begin
        failures = failures + 1;
        $display("[TB] FAIL model_dp t=%0t got=%b want=%b", $time, dp_out, exp_dp);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic r0, input logic [15:0] v0,
                               input logic [3:0] d0, input logic r1, input logic [15:0] v1,
                               input logic [3:0] d1, input int cycles);
    reset = rst;
    req0  = r0;
    val0  = v0;
    dp0   = d0;
    req1  = r1;
    val1  = v1;
    dp1   = d1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] g, input logic [15:0] h,
                             input logic [3:0] d);
    checks = checks + 3;
    if (grant !== g) begin
      failures = failures + 1;
      $display("[TB] FAIL %s grant got=%b want=%b", name, grant, g);
    end
    if ({hex3, hex2, hex1, hex0} !== h) begin
      failures = failures + 1;
      $display("[TB] FAIL %s hex got=%h want=%h", name, {hex3, hex2, hex1, hex0}, h);
    end
    if (dp_out !== d) begin
      failures = failures + 1;
      $display("[TB] FAIL %s dp_out got=%b want=%b", name, dp_out, d);
    end
  endtask

`ifdef DISP_ARB_WAIT_BLINK_EN
  localparam logic [3:0] DWELL_HOLD_DP = 4'b1010;
`else
  localparam logic [3:0] DWELL_HOLD_DP = 4'b0101;
`endif

  initial begin
    $display("[TB] start TICK_DIV=%0d DWELL=%0d", TICK_DIV, DWELL);

    applyStimulus(1, 1, 16'h1234, 4'b0101, 0, 16'hABCD, 4'b0011, 3);
    checkOutput("reset_hold", 2'b00, 16'h0000, 4'b1111);
    applyStimulus(0, 1, 16'h1234, 4'b0101, 0, 16'hABCD, 4'b0011, 1);
    checkOutput("first_grant", 2'b01, 16'h1234, 4'b0101);

    // Grant taken on edge 1; ticks on edges 4, 8, 12; preemption on edge 13.
    applyStimulus(0, 1, 16'h1234, 4'b0101, 1, 16'hABCD, 4'b0011, 11);
    checkOutput("dwell_hold", 2'b01, 16'h1234, DWELL_HOLD_DP);
    applyStimulus(0, 1, 16'h1234, 4'b0101, 1, 16'hABCD, 4'b0011, 1);
    checkOutput("preempt", 2'b10, 16'hABCD, 4'b0011);

    applyStimulus(0, 1, 16'h1234, 4'b0101, 1, 16'h0000, 4'b0011, 1);
    checkOutput("live_zero", 2'b10, 16'h0000, 4'b0011);
    applyStimulus(0, 1, 16'h1234, 4'b0101, 1, 16'hFFFF, 4'b0011, 1);
    checkOutput("live_ffff", 2'b10, 16'hFFFF, 4'b0011);

    applyStimulus(1, 0, 16'h1234, 4'b0101, 0, 16'hFFFF, 4'b0011, 1);
    checkOutput("reset_mid", 2'b00, 16'h0000, 4'b1111);
    applyStimulus(0, 0, 16'h1234, 4'b0101, 0, 16'hFFFF, 4'b0011, 1);
    applyStimulus(0, 1, 16'h1234, 4'b0101, 1, 16'hFFFF, 4'b0011, 1);
    checkOutput("rr_both_first", 2'b01, 16'h1234, 4'b0101);
    applyStimulus(0, 0, 16'h1234, 4'b0101, 0, 16'hFFFF, 4'b0011, 1);
    checkOutput("idle_after_drop", 2'b00, 16'h0000, 4'b1111);
    applyStimulus(0, 1, 16'h1234, 4'b0101, 1, 16'hFFFF, 4'b0011, 1);
    checkOutput("rr_both_second", 2'b10, 16'hFFFF, 4'b0011);

    applyStimulus(0, 1, 16'h1234, 4'b0101, 0, 16'hFFFF, 4'b0011, 1);
    checkOutput("handover", 2'b01, 16'h1234, 4'b0101);
    applyStimulus(0, 1, 16'h1234, 4'b0101, 0, 16'hFFFF, 4'b0011, 19);
    checkOutput("still_owner", 2'b01, 16'h1234, 4'b0101);
    applyStimulus(0, 0, 16'h1234, 4'b0101, 0, 16'hFFFF, 4'b0011, 1);
    checkOutput("drop_idle", 2'b00, 16'h0000, 4'b1111);

    // Directed patterns checked only by the per-cycle model.
    applyStimulus(0, 1, 16'h5A5A, 4'b0000, 1, 16'h0F0F, 4'b1111, 30);
    applyStimulus(0, 1, 16'h1111, 4'b1010, 0, 16'h0F0F, 4'b1111, 7);
    applyStimulus(0, 0, 16'h1111, 4'b1010, 1, 16'h2222, 4'b0101, 9);
    applyStimulus(0, 1, 16'h3333, 4'b1100, 1, 16'h4444, 4'b0011, 13);
    applyStimulus(0, 0, 16'h3333, 4'b1100, 0, 16'h4444, 4'b0011, 3);
    applyStimulus(0, 1, 16'h7777, 4'b0110, 1, 16'h8888, 4'b1001, 16);
    applyStimulus(0, 0, 16'h7777, 4'b0110, 1, 16'h9999, 4'b1001, 5);
    applyStimulus(1, 1, 16'h7777, 4'b0110, 1, 16'h9999, 4'b1001, 2);
    applyStimulus(0, 1, 16'hC0DE, 4'b0001, 0, 16'h9999, 4'b1001, 6);

`ifdef DISP_ARB_WAIT_BLINK_EN
    applyStimulus(1, 1, 16'h1234, 4'b1110, 1, 16'hABCD, 4'b0110, 2);
    applyStimulus(0, 1, 16'h1234, 4'b1110, 1, 16'hABCD, 4'b0110, 1);
    checkOutput("blink_e1", 2'b01, 16'h1234, 4'b1110);
    applyStimulus(0, 1, 16'h1234, 4'b1110, 1, 16'hABCD, 4'b0110, 3);
    checkOutput("blink_e4", 2'b01, 16'h1234, 4'b0001);
    applyStimulus(0, 1, 16'h1234, 4'b1110, 1, 16'hABCD, 4'b0110, 4);
    checkOutput("blink_e8", 2'b01, 16'h1234, 4'b1110);
    applyStimulus(0, 1, 16'h1234, 4'b1110, 1, 16'hABCD, 4'b0110, 4);
    checkOutput("blink_e12", 2'b01, 16'h1234, 4'b0001);
    applyStimulus(0, 1, 16'h1234, 4'b1110, 1, 16'hABCD, 4'b0110, 1);
    checkOutput("blink_switch", 2'b10, 16'hABCD, 4'b0110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
